register_file: RTL and testbench



---
 rtl/register_file.sv | 68 ++++++
 tb/tb_register_file.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/register_file.sv
// register_file: 32 x 32-bit integer register file for the RISC-V core.
// Two combinational read ports with write-first bypass, one synchronous
// write port. Register x0 is hardwired to zero; writing it is the idle idiom.
module register_file #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_REGS   = 32   // must equal 2**ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] i_r_reg_num_1,
    input  logic [ADDR_WIDTH-1:0] i_r_reg_num_2,
    input  logic [ADDR_WIDTH-1:0] i_w_reg_num,
    input  logic [DATA_WIDTH-1:0] i_w_val,
    output logic [DATA_WIDTH-1:0] r_reg_1,
    output logic [DATA_WIDTH-1:0] r_reg_2
);

    // Entry 0 exists so every address indexes the array directly; it is
    // cleared by reset, never written, and masked on the read side anyway.
    logic [DATA_WIDTH-1:0] regs [0:NUM_REGS-1];

    logic [DATA_WIDTH-1:0] stored_1;
    logic [DATA_WIDTH-1:0] stored_2;

    // Read-side priority shared by both ports: reset, then x0, then the
    // in-flight write (bypass), then storage.
    function automatic logic [DATA_WIDTH-1:0] read_select(
        input logic                  rst_in,
        input logic [ADDR_WIDTH-1:0] num,
        input logic [ADDR_WIDTH-1:0] w_num,
        input logic [DATA_WIDTH-1:0] w_val,
        input logic [DATA_WIDTH-1:0] stored
    );
        logic [DATA_WIDTH-1:0] result;
        if (rst_in) begin
            result = '0;
        end else if (num == '0) begin
            result = '0;
        end else if (num == w_num) begin
            result = w_val;
        end else begin
            result = stored;
        end
        return result;
    endfunction

    // Storage update: reset clears everything and drops any presented
    // write; otherwise a nonzero write number stores the full-width value.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (i_w_reg_num != '0) begin
            regs[i_w_reg_num] <= i_w_val;
        end
    end

    // Combinational read of both ports, each resolved independently.
    always_comb begin
        stored_1 = regs[i_r_reg_num_1];
        stored_2 = regs[i_r_reg_num_2];
        r_reg_1  = read_select(rst, i_r_reg_num_1, i_w_reg_num, i_w_val, stored_1);
        r_reg_2  = read_select(rst, i_r_reg_num_2, i_w_reg_num, i_w_val, stored_2);
    end

endmodule

// File: tb/tb_register_file.sv
// tb_register_file: directed scenarios plus randomized traffic against a
// behavioural array model of the register file.
module tb_register_file;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 32;

    logic          clk;
    logic          rst;
    logic [AW-1:0] i_r_reg_num_1;
    logic [AW-1:0] i_r_reg_num_2;
    logic [AW-1:0] i_w_reg_num;
    logic [DW-1:0] i_w_val;
    logic [DW-1:0] r_reg_1;
    logic [DW-1:0] r_reg_2;

    int checks;
    int errors;

    // Architectural state as seen by software.
    logic [DW-1:0] model [NR];

    register_file #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .NUM_REGS  (NR)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_r_reg_num_1(i_r_reg_num_1),
        .i_r_reg_num_2(i_r_reg_num_2),
        .i_w_reg_num  (i_w_reg_num),
        .i_w_val      (i_w_val),
        .r_reg_1      (r_reg_1),
        .r_reg_2      (r_reg_2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop if the sequence ever stalls.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // What a read should return given current inputs and architectural state.
    function automatic logic [DW-1:0] model_read(input logic [AW-1:0] num);
        if (rst) return '0;
        if (num == 0) return '0;
        if (num == i_w_reg_num) return i_w_val;
        return model[num];
    endfunction

    task automatic drive(input logic r, input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                         input logic [AW-1:0] wn, input logic [DW-1:0] wv);
        rst           = r;
        i_r_reg_num_1 = a1;
        i_r_reg_num_2 = a2;
        i_w_reg_num   = wn;
        i_w_val       = wv;
        #1;
    endtask

    // Advance one edge and apply the same edge to the model.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < NR; i++) model[i] = '0;
        end else if (i_w_reg_num != 0) begin
            model[i_w_reg_num] = i_w_val;
        end
        #1;
    endtask

    task automatic expect_both(input string tag, input logic [DW-1:0] e1, input logic [DW-1:0] e2);
        check({tag, "_r1"}, r_reg_1, e1);
        check({tag, "_r2"}, r_reg_2, e2);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < NR; i++) model[i] = '0;
        drive(1'b1, 0, 0, 0, 0);
        @(negedge clk);

        // Initial reset.
        drive(1'b1, 1, 5, 0, 0);
        expect_both("init_rst", 0, 0);
        tick();
        tick();

        // Reset wipes a stored value.
        drive(1'b0, 1, 5, 5, 32'hDEADBEEF);
        expect_both("pre_rst_bypass", 0, 32'hDEADBEEF);
        tick();
        drive(1'b0, 1, 5, 0, 0);
        expect_both("pre_rst_stored", 0, 32'hDEADBEEF);
        drive(1'b1, 1, 5, 0, 0);
        expect_both("rst_c1", 0, 0);
        tick();
        expect_both("rst_c2", 0, 0);
        tick();
        drive(1'b0, 1, 5, 0, 0);
        expect_both("post_rst", 0, 0);
        tick();
        expect_both("post_rst2", 0, 0);

        // Write presented during reset is discarded and not bypassed.
        drive(1'b1, 9, 9, 9, 32'h0000AAAA);
        expect_both("rst_wr_cycle", 0, 0);
        tick();
        drive(1'b0, 9, 9, 0, 0);
        expect_both("rst_wr_dropped", 0, 0);

        // Write / readback.
        drive(1'b0, 1, 2, 1, 10);
        expect_both("wr1_bypass", 10, 0);
        tick();
        drive(1'b0, 1, 2, 0, 0);
        expect_both("wr1_read", 10, 0);
        tick();
        expect_both("wr1_read2", 10, 0);

        // Overwrite with bypass tracking.
        drive(1'b0, 1, 2, 1, 0);
        expect_both("ovw_0", 0, 0);
        tick();
        drive(1'b0, 1, 2, 1, 10);
        expect_both("ovw_10", 10, 0);
        tick();
        drive(1'b0, 1, 2, 1, 20);
        expect_both("ovw_20", 20, 0);
        tick();
        drive(1'b0, 1, 2, 0, 0);
        expect_both("ovw_hold", 20, 0);

        // x0 hardwired.
        drive(1'b0, 0, 0, 0, 32'hFFFFFFFF);
        expect_both("x0_wr", 0, 0);
        tick();
        drive(1'b0, 0, 0, 0, 0);
        expect_both("x0_after", 0, 0);

        // Dual-port independence incl. top bit.
        drive(1'b0, 0, 0, 3, 32'h12345678);
        tick();
        drive(1'b0, 0, 0, 31, 32'h80000000);
        tick();
        drive(1'b0, 3, 31, 0, 0);
        expect_both("dual", 32'h12345678, 32'h80000000);
        drive(1'b0, 31, 3, 0, 0);
        expect_both("dual_swap", 32'h80000000, 32'h12345678);

        // Same register on both ports while it is written.
        drive(1'b0, 7, 7, 7, 32'h55);
        expect_both("same_bypass", 32'h55, 32'h55);
        tick();
        drive(1'b0, 7, 7, 0, 0);
        expect_both("same_stored", 32'h55, 32'h55);

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            logic          r;
            logic [AW-1:0] wn, a1, a2;
            logic [DW-1:0] wv;
            r  = ($urandom_range(0, 59) == 0);
            wn = ($urandom_range(0, 3) == 0) ? '0 : AW'($urandom);
            wv = $urandom;
            if ($urandom_range(0, 7) == 0) wv = ($urandom_range(0, 1) == 0) ? '0 : '1;
            a1 = ($urandom_range(0, 3) == 0) ? wn : AW'($urandom);
            a2 = ($urandom_range(0, 3) == 0) ? wn : AW'($urandom);
            if ($urandom_range(0, 9) == 0) a2 = a1;
            drive(r, a1, a2, wn, wv);
            check("rnd_r1", r_reg_1, model_read(a1));
            check("rnd_r2", r_reg_2, model_read(a2));
            tick();
        end

        // Final sweep of every register with no write in flight.
        for (int i = 0; i < NR; i++) begin
            drive(1'b0, AW'(i), AW'(NR - 1 - i), 0, 0);
            check("sweep_r1", r_reg_1, model_read(AW'(i)));
            check("sweep_r2", r_reg_2, model_read(AW'(NR - 1 - i)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
